// File: rtl/lif_pkg.sv
// lif_pkg: shared definitions for the LIF neuron array.
//   mode_e      - operating mode encoding on the mode port
//   cfg_addr_e  - configuration register select on cfg_addr
//   Rst*        - configuration values loaded on rst
//   idx_width() - neuron index width, never narrower than one bit
package lif_pkg;

   typedef enum logic [1:0] {
      ModeIdle   = 2'b00,
      ModeConfig = 2'b01,
      ModeHold   = 2'b10,
      ModeRun    = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      CfgBeta      = 2'd0,
      CfgThreshold = 2'd1,
      CfgRefrLen   = 2'd2,
      CfgResetMode = 2'd3
   } cfg_addr_e;

   localparam int unsigned RefrW = 8;

   // Threshold resets to all ones (2^WIDTH-1); the fill bit is kept here so the
   // width stays with the instantiating module.
   localparam logic        RstThrFill   = 1'b1;
   localparam int unsigned RstBeta      = 1;
   localparam int unsigned RstRefrLen   = 0;
   localparam logic        RstResetMode = 1'b0;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// lif_neuron_array_if: mode/config/sample/result bundle of the neuron array.
//   slave  (array side): mode, cfg_we, cfg_addr, cfg_data, in_valid, in_idx,
//                        in_current in; out_valid, out_idx, membrane_out, spike out
//   master (driver side): the same signals with directions reversed
interface lif_neuron_array_if
   import lif_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDX_W = 2
);
   mode_e              mode;
   logic               cfg_we;
   cfg_addr_e          cfg_addr;
   logic [WIDTH-1:0]   cfg_data;
   logic               in_valid;
   logic [IDX_W-1:0]   in_idx;
   logic [WIDTH-1:0]   in_current;
   logic               out_valid;
   logic [IDX_W-1:0]   out_idx;
   logic [WIDTH-1:0]   membrane_out;
   logic               spike;

   modport master (
      output mode, cfg_we, cfg_addr, cfg_data, in_valid, in_idx, in_current,
      input  out_valid, out_idx, membrane_out, spike
   );

   modport slave (
      input  mode, cfg_we, cfg_addr, cfg_data, in_valid, in_idx, in_current,
      output out_valid, out_idx, membrane_out, spike
   );
endinterface

// File: rtl/lif_update.sv
// lif_update: combinational leaky integrate-and-fire step for one neuron.
//   in : m (membrane), refr (refractory count), in_current, beta (leak shift),
//        threshold, refr_len, reset_mode
//   out: m_next, refr_next, spike
module lif_update
   import lif_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned BETA_W = 4
) (
   input  logic [WIDTH-1:0]  m,
   input  logic [RefrW-1:0]  refr,
   input  logic [WIDTH-1:0]  in_current,
   input  logic [BETA_W-1:0] beta,
   input  logic [WIDTH-1:0]  threshold,
   input  logic [RefrW-1:0]  refr_len,
   input  logic              reset_mode,
   output logic [WIDTH-1:0]  m_next,
   output logic [RefrW-1:0]  refr_next,
   output logic              spike
);
   logic [WIDTH-1:0] leaked;
   logic [WIDTH:0]   sum_wide;
   logic [WIDTH-1:0] sum;

   always_comb begin
      // A shift of WIDTH or more leaks the membrane away entirely.
      leaked   = (32'(beta) >= WIDTH) ? '0 : (m >> beta);
      sum_wide = {1'b0, in_current} + {1'b0, leaked};
      sum      = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];

      m_next    = sum;
      refr_next = refr;
      spike     = 1'b0;
      if (refr != '0) begin
         // Refractory: input is discarded and the membrane is held at zero.
         m_next    = '0;
         refr_next = refr - RefrW'(1);
      end else if (sum >= threshold) begin
         spike     = 1'b1;
         m_next    = reset_mode ? (sum - threshold) : '0;
         refr_next = refr_len;
      end
   end
endmodule

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N_NEURONS leaky integrate-and-fire neurons sharing one
// update datapath; one sample per cycle, result one cycle later.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - slave side of lif_neuron_array_if (mode, config write, sample in,
//         result out)
module lif_neuron_array
   import lif_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned N_NEURONS = 4,
   parameter int unsigned BETA_W    = 4
) (
   input  logic               clk,
   input  logic               rst,
   lif_neuron_array_if.slave  bus
);
   localparam int unsigned IDX_W = idx_width(N_NEURONS);

   logic [WIDTH-1:0]  mem_q  [N_NEURONS];
   logic [RefrW-1:0]  refr_q [N_NEURONS];
   logic [BETA_W-1:0] beta_q;
   logic [WIDTH-1:0]  thr_q;
   logic [RefrW-1:0]  refr_len_q;
   logic              reset_mode_q;

   logic              out_valid_q;
   logic [IDX_W-1:0]  out_idx_q;
   logic [WIDTH-1:0]  mem_out_q;
   logic              spike_q;

   logic              idx_ok;
   logic [WIDTH-1:0]  m_sel;
   logic [RefrW-1:0]  refr_sel;
   logic [WIDTH-1:0]  m_nxt;
   logic [RefrW-1:0]  refr_nxt;
   logic              spike_nxt;

   // Indices past the last neuron are dropped when N_NEURONS is not a power of two.
   assign idx_ok = (32'(bus.in_idx) < N_NEURONS);

   always_comb begin
      m_sel    = '0;
      refr_sel = '0;
      if (idx_ok) begin
         m_sel    = mem_q[bus.in_idx];
         refr_sel = refr_q[bus.in_idx];
      end
   end

   lif_update #(
      .WIDTH  (WIDTH),
      .BETA_W (BETA_W)
   ) u_update (
      .m          (m_sel),
      .refr       (refr_sel),
      .in_current (bus.in_current),
      .beta       (beta_q),
      .threshold  (thr_q),
      .refr_len   (refr_len_q),
      .reset_mode (reset_mode_q),
      .m_next     (m_nxt),
      .refr_next  (refr_nxt),
      .spike      (spike_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(N_NEURONS); i++) begin
            mem_q[i]  <= '0;
            refr_q[i] <= '0;
         end
         beta_q       <= BETA_W'(RstBeta);
         thr_q        <= {WIDTH{RstThrFill}};
         refr_len_q   <= RefrW'(RstRefrLen);
         reset_mode_q <= RstResetMode;
         out_valid_q  <= 1'b0;
         out_idx_q    <= '0;
         mem_out_q    <= '0;
         spike_q      <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         unique case (bus.mode)
            ModeIdle: begin
               for (int i = 0; i < int'(N_NEURONS); i++) begin
                  mem_q[i]  <= '0;
                  refr_q[i] <= '0;
               end
            end
            ModeConfig: begin
               if (bus.cfg_we) begin
                  unique case (bus.cfg_addr)
                     CfgBeta:      beta_q       <= bus.cfg_data[BETA_W-1:0];
                     CfgThreshold: thr_q        <= bus.cfg_data;
                     CfgRefrLen:   refr_len_q   <= bus.cfg_data[RefrW-1:0];
                     CfgResetMode: reset_mode_q <= bus.cfg_data[0];
                  endcase
               end
            end
            ModeHold: begin
            end
            ModeRun: begin
               if (bus.in_valid && idx_ok) begin
                  mem_q[bus.in_idx]  <= m_nxt;
                  refr_q[bus.in_idx] <= refr_nxt;
                  out_valid_q        <= 1'b1;
                  out_idx_q          <= bus.in_idx;
                  mem_out_q          <= m_nxt;
                  spike_q            <= spike_nxt;
               end
            end
         endcase
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.out_idx      = out_idx_q;
   assign bus.membrane_out = mem_out_q;
   assign bus.spike        = spike_q;
endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: directed bench for lif_neuron_array (WIDTH=8, 4 neurons)
// with a plain-arithmetic neuron model checked every cycle, plus a 3-neuron
// instance fed the same stream to exercise out-of-range index dropping.
module tb_lif_neuron_array;
   import lif_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lif_neuron_array_if #(.WIDTH(8), .IDX_W(2)) bus ();
   lif_neuron_array_if #(.WIDTH(8), .IDX_W(2)) bus3 ();

   lif_neuron_array #(.WIDTH(8), .N_NEURONS(4), .BETA_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   lif_neuron_array #(.WIDTH(8), .N_NEURONS(3), .BETA_W(4)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   // Model state
   int m_mem [4];
   int m_refr [4];
   int m_beta, m_thr, m_rlen, m_rmode;
   bit exp_valid = 0, exp3_valid = 0;
   int exp_idx = 0, exp_m = 0, exp_sp = 0;
   bit chk_en = 0;
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
      end
   endtask

   // One cycle of stimulus, driven at the falling edge; the model advances to
   // what the outputs must show after the following rising edge.
   task automatic step(input bit r, input int md, input bit we, input int addr,
                       input int data, input bit v, input int idx, input int cur);
      int sh, sum, sp;
      @(negedge clk);
      rst = r;
      bus.mode  = mode_e'(md[1:0]);   bus3.mode  = mode_e'(md[1:0]);
      bus.cfg_we = we;                bus3.cfg_we = we;
      bus.cfg_addr = cfg_addr_e'(addr[1:0]); bus3.cfg_addr = cfg_addr_e'(addr[1:0]);
      bus.cfg_data = 8'(data);        bus3.cfg_data = 8'(data);
      bus.in_valid = v;               bus3.in_valid = v;
      bus.in_idx = 2'(idx);           bus3.in_idx = 2'(idx);
      bus.in_current = 8'(cur);       bus3.in_current = 8'(cur);

      exp_valid  = 0;
      exp3_valid = 0;
      if (r) begin
         for (int i = 0; i < 4; i++) begin m_mem[i] = 0; m_refr[i] = 0; end
         m_beta = 1; m_thr = 255; m_rlen = 0; m_rmode = 0;
         exp_idx = 0; exp_m = 0; exp_sp = 0;
      end else if (md == 0) begin
         for (int i = 0; i < 4; i++) begin m_mem[i] = 0; m_refr[i] = 0; end
      end else if (md == 1 && we) begin
         case (addr)
            0: m_beta  = data & 15;
            1: m_thr   = data & 255;
            2: m_rlen  = data & 255;
            default: m_rmode = data & 1;
         endcase
      end else if (md == 3 && v && idx < 4) begin
         if (m_refr[idx] != 0) begin
            m_refr[idx] = m_refr[idx] - 1;
            m_mem[idx]  = 0;
            sp = 0;
         end else begin
            sh  = (m_beta >= 8) ? 0 : (m_mem[idx] >> m_beta);
            sum = cur + sh;
            if (sum > 255) sum = 255;
            sp = (sum >= m_thr) ? 1 : 0;
            if (sp == 1) begin
               m_mem[idx]  = (m_rmode != 0) ? sum - m_thr : 0;
               m_refr[idx] = m_rlen;
            end else begin
               m_mem[idx] = sum;
            end
         end
         exp_valid  = 1;
         exp3_valid = (idx < 3);
         exp_idx = idx; exp_m = m_mem[idx]; exp_sp = sp;
      end
   endtask

   task automatic cfg(input int addr, input int data);
      step(0, 1, 1, addr, data, 0, 0, 0);
   endtask

   task automatic run(input int idx, input int cur);
      step(0, 3, 0, 0, 0, 1, idx, cur);
   endtask

   // Hand-computed expectation for the sample just issued; pins DUT and model.
   task automatic pin(input string name, input int idx, input int m, input int sp);
      @(posedge clk);
      #1;
      check({name, "_valid"}, int'(bus.out_valid), 1);
      check({name, "_idx"}, int'(bus.out_idx), idx);
      check({name, "_mem"}, int'(bus.membrane_out), m);
      check({name, "_spike"}, int'(bus.spike), sp);
      check({name, "_n3_valid"}, int'(bus3.out_valid), (idx < 3) ? 1 : 0);
      check({name, "_model_mem"}, exp_m, m);
      check({name, "_model_spike"}, exp_sp, sp);
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("out_valid", int'(bus.out_valid), int'(exp_valid));
         check("out_idx", int'(bus.out_idx), exp_idx);
         check("membrane_out", int'(bus.membrane_out), exp_m);
         check("spike", int'(bus.spike), exp_sp);
         check("n3_out_valid", int'(bus3.out_valid), int'(exp3_valid));
         if (exp3_valid) begin
            check("n3_out_idx", int'(bus3.out_idx), exp_idx);
            check("n3_membrane_out", int'(bus3.membrane_out), exp_m);
            check("n3_spike", int'(bus3.spike), exp_sp);
         end
      end
   end

   initial begin
      bus.mode = ModeIdle;  bus.cfg_we = 0;  bus.cfg_addr = CfgBeta;  bus.cfg_data = 0;
      bus.in_valid = 0;     bus.in_idx = 0;  bus.in_current = 0;
      bus3.mode = ModeIdle; bus3.cfg_we = 0; bus3.cfg_addr = CfgBeta; bus3.cfg_data = 0;
      bus3.in_valid = 0;    bus3.in_idx = 0; bus3.in_current = 0;

      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk_en = 1;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_membrane_out", int'(bus.membrane_out), 0);

      // Basic integrate and fire, reset-to-zero
      cfg(0, 1); cfg(1, 100); cfg(2, 0);
      run(2, 80); pin("p34a", 2, 80, 0);
      run(2, 80); pin("p34b", 2, 0, 1);

      // Refractory period of two samples
      cfg(2, 2);
      run(2, 100); pin("p35_fire", 2, 0, 1);
      run(2, 50);  pin("p35_r1", 2, 0, 0);
      run(2, 50);  pin("p35_r2", 2, 0, 0);
      run(2, 50);  pin("p35_out", 2, 50, 0);

      // Saturation with no leak shift; HOLD ignores a strobe
      cfg(0, 0); cfg(1, 255); cfg(2, 0);
      step(0, 2, 0, 0, 0, 1, 1, 99);
      run(1, 200); pin("p36a", 1, 200, 0);
      run(1, 200); pin("p36b", 1, 0, 1);

      // Subtractive reset
      cfg(3, 1); cfg(1, 100);
      run(0, 70); pin("p37a", 0, 70, 0);
      run(0, 70); pin("p37b", 0, 40, 1);

      // Interleaved neurons; idx 3 is out of range for the 3-neuron instance
      run(0, 10); pin("p38_i0a", 0, 50, 0);
      run(3, 30); pin("p38_i3a", 3, 30, 0);
      run(0, 10); pin("p38_i0b", 0, 60, 0);
      run(3, 30); pin("p38_i3b", 3, 60, 0);
      run(3, 50); pin("p38_i3c", 3, 10, 1);

      // Result completes across a mode change, then IDLE clears membranes
      run(0, 5); pin("p27_run", 0, 65, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      run(0, 5);  pin("p38_clr0", 0, 5, 0);
      run(0, 96); pin("p38_thr", 0, 1, 1);
      run(3, 20); pin("p38_clr3", 3, 20, 0);

      // Reset during a RUN sample, then defaults observed through behaviour
      run(1, 10);
      step(1, 3, 0, 0, 0, 1, 2, 77);
      @(posedge clk);
      #1;
      check("p39_rst_kill", int'(bus.out_valid), 0);
      run(1, 200); pin("p39a", 1, 200, 0);
      run(1, 100); pin("p39_beta1", 1, 200, 0);
      run(1, 255); pin("p39_thr255", 1, 0, 1);

      step(0, 2, 0, 0, 0, 0, 0, 0);
      step(0, 2, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lif_neuron_array.md
LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 SHALL have parameter WIDTH, default 8: membrane, threshold and input current width.
REQ-002 SHALL have parameter N_NEURONS, default 4: neuron count; IDX_W = max(1, clog2(N_NEURONS)).
REQ-003 SHALL have parameter BETA_W, default 4: leak shift field width.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port mode, input, 2: 00 IDLE, 01 CONFIG, 10 HOLD, 11 RUN.
REQ-007 SHALL have port cfg_we, input, 1: config write strobe, honoured only in CONFIG.
REQ-008 SHALL have port cfg_addr, input, 2: 0 beta, 1 threshold, 2 refractory length, 3 reset_mode.
REQ-009 SHALL have port cfg_data, input, WIDTH: config write data, low bits used per register.
REQ-010 SHALL have port in_valid, input, 1: input sample strobe, honoured only in RUN.
REQ-011 SHALL have port in_idx, input, IDX_W: target neuron.
REQ-012 SHALL have port in_current, input, WIDTH: unsigned input current.
REQ-013 SHALL have port out_valid, output, 1: result strobe.
REQ-014 SHALL have ports out_idx (IDX_W), membrane_out (WIDTH) and spike (1), all outputs: index, post-update membrane, spike flag of the result.

Function
REQ-015 SHALL hold, per neuron, a WIDTH-bit membrane and an 8-bit refractory counter.
REQ-016 SHALL hold shared registers beta (BETA_W), threshold (WIDTH), refr_len (8) and reset_mode (1).
REQ-017 SHALL, in IDLE, clear all membranes and refractory counters each cycle and retain config.
REQ-018 SHALL, in CONFIG with cfg_we, write cfg_data into the cfg_addr register on the next edge.
REQ-019 SHALL, in HOLD, leave all state unchanged and ignore in_valid.
REQ-020 SHALL treat an accepted sample as RUN && in_valid; an in_idx >= N_NEURONS SHALL be dropped with no state change and no out_valid.
REQ-021 SHALL, for an accepted sample to a neuron with refr != 0: decrement refr, force the membrane to 0, and report membrane_out=0, spike=0.
REQ-022 SHALL, for an accepted sample to a neuron with refr == 0, compute sum = min(in_current + (m >> beta), 2^WIDTH-1), where a shift >= WIDTH yields 0.
REQ-023 SHALL flag spike = (sum >= threshold); threshold 0 therefore spikes on every non-refractory sample.
REQ-024 SHALL, on spike, set the next membrane to 0 if reset_mode=0, or to sum - threshold if reset_mode=1, and load refr with refr_len.
REQ-025 SHALL, without spike, set the next membrane to sum.
REQ-026 SHALL report with latency 1: out_valid, out_idx, membrane_out (the membrane after the update) and spike are registered the cycle after acceptance; out_valid is 0 otherwise and the other outputs hold.
REQ-027 SHALL complete a result registered on a RUN cycle on the next cycle even if mode changes.
REQ-028 SHALL sustain one sample per cycle, including back-to-back samples to the same neuron, with no stall.

Reset
REQ-029 SHALL, on rst, clear membranes, refractory counters, out_valid, out_idx, membrane_out and spike to 0.
REQ-030 SHALL, on rst, set beta=1, threshold=2^WIDTH-1, refr_len=0 and reset_mode=0.
REQ-031 SHALL let rst override every mode and any in-flight result: out_valid=0 on the cycle after rst.

Structure
REQ-032 SHALL place the mode encodings, cfg_addr encodings and the reset defaults of REQ-030 in the shared package lif_pkg.
REQ-033 SHALL implement the REQ-022..REQ-025 datapath in a combinational sub-module lif_update: inputs m, refr, in_current and config; outputs next m, next refr and spike.

Verification (WIDTH=8, N_NEURONS=4)
REQ-034 SHALL cover: beta=1, thr=100, refr_len=0; idx2 gets 80 then 80 -> out (2,80,0), then (2,120 pre-reset, reported 0, spike=1), and neuron 2 membrane is 0.
REQ-035 SHALL cover: refr_len=2 after the REQ-034 spike; three samples of 50 to idx2 -> membrane_out 0,0 with spike=0, then 50.
REQ-036 SHALL cover: beta=0, thr=255; idx1 gets 200, 200 -> 200 then saturated 255 with spike=1.
REQ-037 SHALL cover: reset_mode=1, beta=0, thr=100; idx0 gets 70, 70 -> 70, then spike=1 with membrane_out 40.
REQ-038 SHALL cover: interleaved samples to idx0 and idx3 with out_idx tracking; in_idx out of range dropped; IDLE for 1 cycle then RUN clears the membranes while thr is kept.
REQ-039 SHALL cover: rst asserted while in_valid=1 in RUN -> out_valid=0 next cycle, and a config readback via behaviour shows thr=255, beta=1.
